demux_1to4: RTL and testbench
=============================

# demux_1to4

Registered 1-to-4 demultiplexer. One data input is steered to one of four outputs (saida_A..saida_D) chosen by a 2-bit select, and every non-selected output is driven to zero. It sits between a single-source producer and four consumer lanes. It also reports the active lane as a one-hot code and counts select changes for debug.

## Interface
Parameters:
- WIDTH, default 1: data width of entrada and of each saida_*.
- CNT_W, default 8: width of the sel_changes counter.

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous and active-high; clears all state.
- en  in  1  update enable; 1 = capture the routing on this edge, 0 = hold.
- entrada  in  WIDTH  data to route.
- sel  in  2  lane select: 00 = A, 01 = B, 10 = C, 11 = D.
- saida_A  out  WIDTH  lane A output.
- saida_B  out  WIDTH  lane B output.
- saida_C  out  WIDTH  lane C output.
- saida_D  out  WIDTH  lane D output.
- lane  out  4  one-hot registered lane: bit0 = A, bit1 = B, bit2 = C, bit3 = D.
- sel_changes  out  CNT_W  saturating count of edges where the captured sel differs from the previously captured sel.

Declaration order, for positional instantiation: saida_A, saida_B, saida_C, saida_D, entrada, sel, clock, reset, en, lane, sel_changes.

## Operation
- Routing on a rising edge with en=1:
  - The output selected by sel gets entrada.
  - The other three outputs get all zeros.
  - lane gets the one-hot code of sel.
- Select decode:
  - sel=00: saida_A=entrada, saida_B/C/D=0, lane=0001.
  - sel=01: saida_B=entrada, lane=0010.
  - sel=10: saida_C=entrada, lane=0100.
  - sel=11 (the default branch of the decode): saida_D=entrada, lane=1000.
- en=0: all outputs, lane and sel_changes hold their values.
- The selected output passes entrada as-is, including zero data. A selected lane carrying 0 is indistinguishable on saida_* from an unselected lane; lane disambiguates the two.
- sel_changes:
  - An internal register, last_sel, holds the last captured sel; it resets to 00.
  - On an edge with en=1 and sel != last_sel, sel_changes increments by 1. It saturates at 2^CNT_W-1 and does not wrap.
  - last_sel updates on every edge with en=1.
- At most one saida_* is ever nonzero. lane is always exactly one-hot, including after reset.

## Timing
- Latency is 1 clock from entrada/sel/en to the outputs. There is no combinational path from the inputs to the outputs.
- Reset state (asynchronous, takes effect immediately when reset rises):
  - saida_A..D = 0.
  - lane = 0001, matching last_sel = 00.
  - sel_changes = 0.
- Reset asserted mid-operation: all state clears at once. The first edge after reset deasserts behaves as a normal capture relative to last_sel = 00.
- Reset and a clock edge together: reset wins.
- Simultaneous sel and entrada change before an edge: both are captured on that same edge, so the old lane clears and the new lane loads in one cycle.
- sel wrapping from 11 to 00 counts as a change.

## Test plan
- Reset then hold, with sel=00, entrada=0, en=1: after reset all saida=0, lane=0001, sel_changes=0. After the next edge, outputs are unchanged.
- Lane A data toggle, sel=00: set entrada=1, then after 1 edge saida_A=1 and B/C/D=0. Set entrada=0, then after 1 edge saida_A=0.
- Select sweep, with entrada=1 and sel stepping 00→01→10→11→00, one step per 4 edges:
  - On each step, only the matching saida is 1 and lane follows 0001/0010/0100/1000/0001.
  - sel_changes ends at 4.
- Enable hold: with sel=10 and entrada=1 captured, drop en and change sel to 01 and entrada to 0. Outputs stay saida_C=1, lane=0100, and the counter does not change.
- Async reset mid-stream, with sel=11 and entrada=1 active: pulse reset between edges. saida_D goes to 0 immediately, lane=0001 and sel_changes=0 without a clock edge.
- Saturation, with CNT_W=2: toggle sel every edge for 6 edges; sel_changes stops at 3.

Source files
------------

// File: rtl/demux_1to4_if.sv
// Signal bundle for the 1-to-4 demultiplexer: producer-side controls and
// the four consumer lanes plus debug status.
interface demux_1to4_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] entrada;
  logic [1:0]       sel;
  logic [WIDTH-1:0] saida_A;
  logic [WIDTH-1:0] saida_B;
  logic [WIDTH-1:0] saida_C;
  logic [WIDTH-1:0] saida_D;
  logic [3:0]       lane;
  logic [CNT_W-1:0] sel_changes;

  modport master (
    output en, entrada, sel,
    input  saida_A, saida_B, saida_C, saida_D, lane, sel_changes
  );

  modport slave (
    input  en, entrada, sel,
    output saida_A, saida_B, saida_C, saida_D, lane, sel_changes
  );
endinterface

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer with one-hot lane report and a saturating
// counter of select changes. All outputs come straight from flops.
module demux_1to4 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  output logic [WIDTH-1:0] saida_A,
  output logic [WIDTH-1:0] saida_B,
  output logic [WIDTH-1:0] saida_C,
  output logic [WIDTH-1:0] saida_D,
  input  logic [WIDTH-1:0] entrada,
  input  logic [1:0]       sel,
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [3:0]       lane,
  output logic [CNT_W-1:0] sel_changes
);

  logic [WIDTH-1:0] saida_q [4];
  logic [WIDTH-1:0] saida_d [4];
  logic [3:0]       lane_q;
  logic [3:0]       lane_d;
  logic [1:0]       last_sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    lane_d = 4'b0001 << sel;
    cnt_d  = cnt_q;
    // Saturate rather than wrap so a long-running debug count never looks small.
    if ((sel != last_sel_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign saida_d[gi] = lane_d[gi] ? entrada : '0;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          saida_q[gi] <= '0;
        end else if (en) begin
          saida_q[gi] <= saida_d[gi];
        end
      end
    end
  endgenerate

  // lane resets to A so it stays one-hot and consistent with last_sel = 00.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q     <= 4'b0001;
      last_sel_q <= 2'b00;
      cnt_q      <= '0;
    end else if (en) begin
      lane_q     <= lane_d;
      last_sel_q <= sel;
      cnt_q      <= cnt_d;
    end
  end

  assign saida_A     = saida_q[0];
  assign saida_B     = saida_q[1];
  assign saida_C     = saida_q[2];
  assign saida_D     = saida_q[3];
  assign lane        = lane_q;
  assign sel_changes = cnt_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Directed self-checking bench for demux_1to4: default instance for routing,
// enable and reset behaviour, plus a CNT_W=2 instance for counter saturation.
module tb_demux_1to4;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  demux_1to4_if #(.WIDTH(1), .CNT_W(8)) bus ();
  demux_1to4_if #(.WIDTH(1), .CNT_W(2)) bus2 ();

  demux_1to4 #(.WIDTH(1), .CNT_W(8)) dut (
    .saida_A     (bus.saida_A),
    .saida_B     (bus.saida_B),
    .saida_C     (bus.saida_C),
    .saida_D     (bus.saida_D),
    .entrada     (bus.entrada),
    .sel         (bus.sel),
    .clock       (clock),
    .reset       (reset),
    .en          (bus.en),
    .lane        (bus.lane),
    .sel_changes (bus.sel_changes)
  );

  demux_1to4 #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .saida_A     (bus2.saida_A),
    .saida_B     (bus2.saida_B),
    .saida_C     (bus2.saida_C),
    .saida_D     (bus2.saida_D),
    .entrada     (bus2.entrada),
    .sel         (bus2.sel),
    .clock       (clock),
    .reset       (reset),
    .en          (bus2.en),
    .lane        (bus2.lane),
    .sel_changes (bus2.sel_changes)
  );

  logic [3:0] dcba;
  logic [3:0] dcba2;
  assign dcba  = {bus.saida_D, bus.saida_C, bus.saida_B, bus.saida_A};
  assign dcba2 = {bus2.saida_D, bus2.saida_C, bus2.saida_B, bus2.saida_A};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input string tag);
    @(posedge clock);
    #1;
    $display("[%0t] %s: sel=%b en=%b entrada=%b -> DCBA=%b lane=%b cnt=%0d",
             $time, tag, bus.sel, bus.en, bus.entrada, dcba, bus.lane, bus.sel_changes);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b1; bus.sel = 2'b00; bus.entrada = 1'b0;
    bus2.en = 1'b0; bus2.sel = 2'b00; bus2.entrada = 1'b0;
    #3;
    n_checks++;
    if (dcba !== 4'b0000) begin n_fail++; $display("FAIL reset_outs: got %b want 0000", dcba); end
    n_checks++;
    if (bus.lane !== 4'b0001) begin n_fail++; $display("FAIL reset_lane: got %b want 0001", bus.lane); end
    n_checks++;
    if (bus.sel_changes !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.sel_changes); end
    // clock edge while reset held: reset must win
    bus.entrada = 1'b1;
    step("reset_edge");
    n_checks++;
    if (dcba !== 4'b0000) begin n_fail++; $display("FAIL reset_wins: got %b want 0000", dcba); end
    bus.entrada = 1'b0;
    reset = 1'b0;
    step("reset_hold");
    n_checks++;
    if (dcba !== 4'b0000 || bus.lane !== 4'b0001 || bus.sel_changes !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got dcba=%b lane=%b cnt=%0d want 0000/0001/0", dcba, bus.lane, bus.sel_changes);
    end
  endtask

  task automatic test_lane_a();
    bus.entrada = 1'b1;
    step("lane_a_one");
    n_checks++;
    if (dcba !== 4'b0001) begin n_fail++; $display("FAIL lane_a_one: got %b want 0001", dcba); end
    bus.entrada = 1'b0;
    step("lane_a_zero");
    n_checks++;
    if (dcba !== 4'b0000 || bus.lane !== 4'b0001) begin
      n_fail++; $display("FAIL lane_a_zero: got dcba=%b lane=%b want 0000/0001", dcba, bus.lane);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] sel_tab  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [3:0] lane_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] cnt_tab  [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    bus.entrada = 1'b1;
    for (int s = 0; s < 5; s++) begin
      bus.sel = sel_tab[s];
      for (int e = 0; e < 4; e++) begin
        step("sweep");
        n_checks++;
        if (dcba !== lane_tab[s] || bus.lane !== lane_tab[s] || bus.sel_changes !== cnt_tab[s]) begin
          n_fail++;
          $display("FAIL sweep_sel%b: got dcba=%b lane=%b cnt=%0d want %b/%b/%0d",
                   sel_tab[s], dcba, bus.lane, bus.sel_changes, lane_tab[s], lane_tab[s], cnt_tab[s]);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    bus.sel = 2'b10; bus.entrada = 1'b1;
    step("en_capture");
    n_checks++;
    if (dcba !== 4'b0100 || bus.sel_changes !== 8'd5) begin
      n_fail++; $display("FAIL en_capture: got dcba=%b cnt=%0d want 0100/5", dcba, bus.sel_changes);
    end
    bus.en = 1'b0; bus.sel = 2'b01; bus.entrada = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("en_hold");
      n_checks++;
      if (dcba !== 4'b0100 || bus.lane !== 4'b0100 || bus.sel_changes !== 8'd5) begin
        n_fail++;
        $display("FAIL en_hold: got dcba=%b lane=%b cnt=%0d want 0100/0100/5", dcba, bus.lane, bus.sel_changes);
      end
    end
    bus.en = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.sel = 2'b11; bus.entrada = 1'b1;
    step("pre_reset");
    n_checks++;
    if (dcba !== 4'b1000 || bus.sel_changes !== 8'd6) begin
      n_fail++; $display("FAIL pre_reset: got dcba=%b cnt=%0d want 1000/6", dcba, bus.sel_changes);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (dcba !== 4'b0000 || bus.lane !== 4'b0001 || bus.sel_changes !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got dcba=%b lane=%b cnt=%0d want 0000/0001/0", dcba, bus.lane, bus.sel_changes);
    end
    reset = 1'b0;
    step("post_reset");
    n_checks++;
    if (dcba !== 4'b1000 || bus.lane !== 4'b1000 || bus.sel_changes !== 8'd1) begin
      n_fail++;
      $display("FAIL post_reset: got dcba=%b lane=%b cnt=%0d want 1000/1000/1", dcba, bus.lane, bus.sel_changes);
    end
  endtask

  task automatic test_back_to_back();
    bus.sel = 2'b00; bus.entrada = 1'b1;
    step("b2b_wrap");
    n_checks++;
    if (dcba !== 4'b0001 || bus.lane !== 4'b0001 || bus.sel_changes !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b_wrap: got dcba=%b lane=%b cnt=%0d want 0001/0001/2", dcba, bus.lane, bus.sel_changes);
    end
    bus.sel = 2'b01; bus.entrada = 1'b0;
    step("b2b_zero_data");
    n_checks++;
    if (dcba !== 4'b0000 || bus.lane !== 4'b0010 || bus.sel_changes !== 8'd3) begin
      n_fail++;
      $display("FAIL b2b_zero_data: got dcba=%b lane=%b cnt=%0d want 0000/0010/3", dcba, bus.lane, bus.sel_changes);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] cnt_tab [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    bus2.en = 1'b1; bus2.entrada = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus2.sel = (i % 2 == 0) ? 2'b01 : 2'b00;
      @(posedge clock);
      #1;
      $display("[%0t] sat: sel=%b -> DCBA=%b lane=%b cnt=%0d", $time, bus2.sel, dcba2, bus2.lane, bus2.sel_changes);
      n_checks++;
      if (bus2.sel_changes !== cnt_tab[i] || bus2.lane !== ((i % 2 == 0) ? 4'b0010 : 4'b0001)) begin
        n_fail++;
        $display("FAIL sat_%0d: got cnt=%0d lane=%b want cnt=%0d", i, bus2.sel_changes, bus2.lane, cnt_tab[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lane_a();
    test_sweep();
    test_enable_hold();
    test_async_reset();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
